// File: rtl/edge_detector_multi.sv
// edge_detector_multi: NUM_CH independent glitch-filtered edge detectors.
// Each channel has a clk_en-gated level filter, run-time edge mode selection,
// a one-clock pulse, and a sticky pending flag. irq is the OR of pending.
// Optional macro EDGE_DETECTOR_MULTI_COUNT_EN adds saturating per-channel
// edge counters. Without it, edge_count is tied to zero.
module edge_detector_multi #(
    parameter int unsigned NUM_CH              = 8,
    parameter int unsigned FILTER_CYCLES       = 1,
    parameter bit          INITIAL_INPUT_LEVEL = 1'b0,
    parameter int unsigned CNT_W               = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clk_en,
    input  logic [NUM_CH-1:0]         in,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]         clr,
    output logic [NUM_CH-1:0]         level,
    output logic [NUM_CH-1:0]         edge_pulse,
    output logic [NUM_CH-1:0]         pending,
    output logic                      irq,
    output logic [NUM_CH*CNT_W-1:0]   edge_count
);

    localparam int unsigned     FW     = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0]   F_LAST = FW'(FILTER_CYCLES - 1);

    logic [NUM_CH-1:0]          level_q, level_d;
    logic [NUM_CH-1:0][FW-1:0]  fcnt_q, fcnt_d;
    logic [NUM_CH-1:0]          pulse_q, pulse_d;
    logic [NUM_CH-1:0]          pend_q, pend_d;
    logic                       irq_q, irq_d;
    logic [NUM_CH-1:0]          qual;

    // Filter, edge qualification and pending/irq next state
    always_comb begin
        level_d = level_q;
        fcnt_d  = fcnt_q;
        qual    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clk_en) begin
                if (in[i] == level_q[i]) begin
                    fcnt_d[i] = '0;
                end else if (fcnt_q[i] == F_LAST) begin
                    level_d[i] = in[i];
                    fcnt_d[i]  = '0;
                    // new level 1 is a rising edge (mode bit 0), 0 is falling (bit 1)
                    qual[i]    = in[i] ? mode[2*i] : mode[2*i+1];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end
        end
        pulse_d = qual;
        pend_d  = (pend_q & ~clr) | qual;
        irq_d   = |pend_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q <= {NUM_CH{INITIAL_INPUT_LEVEL}};
            fcnt_q  <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    assign level      = level_q;
    assign edge_pulse = pulse_q;
    assign pending    = pend_q;
    assign irq        = irq_q;

`ifdef EDGE_DETECTOR_MULTI_COUNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] ecnt_q, ecnt_d;

    // Saturating edge counters; clear takes priority but counts a coincident edge
    always_comb begin
        ecnt_d = ecnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr[i]) begin
                ecnt_d[i] = CNT_W'(qual[i]);
            end else if (qual[i] && (ecnt_q[i] != {CNT_W{1'b1}})) begin
                ecnt_d[i] = ecnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign edge_count = ecnt_q;
`else
    assign edge_count = '0;
`endif

endmodule

// File: tb/tb_edge_detector_multi.sv
// Self-checking bench for edge_detector_multi (NUM_CH=4, FILTER_CYCLES=3,
// INITIAL_INPUT_LEVEL=1, CNT_W=2): directed checks plus randomized stimulus
// compared every cycle against a behavioural model.
module tb_edge_detector_multi;

    localparam int NCH  = 4;
    localparam int FC   = 3;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            clk_en;
    logic [NCH-1:0]  in;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]  clr;
    logic [NCH-1:0]  level, edge_pulse, pending;
    logic            irq;
    logic [NCH*CW-1:0] edge_count;

    edge_detector_multi #(
        .NUM_CH(NCH), .FILTER_CYCLES(FC), .INITIAL_INPUT_LEVEL(1'b1), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .in(in), .mode(mode),
        .clr(clr), .level(level), .edge_pulse(edge_pulse), .pending(pending),
        .irq(irq), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    // Model state: accepted level, run of consecutive differing samples,
    // last-cycle pulse, sticky flags and edge tallies.
    bit m_lvl   [NCH];
    int m_run   [NCH];
    bit m_pulse [NCH];
    bit m_pend  [NCH];
    int m_cnt   [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [NCH-1:0] pack_bits(input bit v [NCH]);
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [NCH*CW-1:0] pack_cnt();
        logic [NCH*CW-1:0] r;
        r = '0;
`ifdef EDGE_DETECTOR_MULTI_COUNT_EN
        for (int i = 0; i < NCH; i++) r[i*CW +: CW] = CW'(m_cnt[i]);
`endif
        return r;
    endfunction

    // Behavioural model, advanced at each rising edge from the sampled inputs
    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < NCH; i++) begin
            bit q;
            q = 1'b0;
            if (!reset_n) begin
                m_lvl[i] = 1'b1;
                m_run[i] = 0;
                m_pend[i] = 1'b0;
                m_cnt[i] = 0;
            end else begin
                if (clk_en) begin
                    if (in[i] == m_lvl[i]) m_run[i] = 0;
                    else m_run[i] = m_run[i] + 1;
                    if (m_run[i] == FC) begin
                        m_lvl[i] = in[i];
                        m_run[i] = 0;
                        q = in[i] ? mode[2*i] : mode[2*i+1];
                    end
                end
                m_pend[i] = (m_pend[i] && !clr[i]) || q;
                if (clr[i]) m_cnt[i] = q ? 1 : 0;
                else if (q && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            end
            m_pulse[i] = q;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            logic [NCH-1:0] ep;
            ep = pack_bits(m_pend);
            check("level", 32'(level), 32'(pack_bits(m_lvl)));
            check("edge_pulse", 32'(edge_pulse), 32'(pack_bits(m_pulse)));
            check("pending", 32'(pending), 32'(ep));
            check("irq", 32'(irq), 32'(|ep));
            check("edge_count", 32'(edge_count), 32'(pack_cnt()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        clk_en  = 1'b1;
        in      = 4'hF;
        mode    = 8'hFF;
        clr     = '0;
        step(2);
        check("rst_level", 32'(level), 32'hF);
        check("rst_pulse", 32'(edge_pulse), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // two-sample glitch on ch1 is rejected
        reset_n = 1'b1;
        in = 4'hD;
        step(2);
        in = 4'hF;
        step(1);
        check("glitch_level", 32'(level), 32'hF);
        check("glitch_pulse", 32'(edge_pulse), 32'h0);

        // three samples accepted on the third edge
        in = 4'hD;
        step(2);
        check("pre_accept_level", 32'(level), 32'hF);
        step(1);
        check("accept_level", 32'(level), 32'hD);
        check("accept_pulse", 32'(edge_pulse), 32'h2);
        check("accept_pending", 32'(pending), 32'h2);
        check("accept_irq", 32'(irq), 32'h1);
        step(1);
        check("pulse_one_cycle", 32'(edge_pulse), 32'h0);
        clr = 4'h2;
        step(1);
        clr = '0;
        check("clr_pending", 32'(pending), 32'h0);
        check("clr_irq", 32'(irq), 32'h0);

        // reset mid-filter discards partial count
        in = 4'hF;
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("midrst_level", 32'(level), 32'hF);
        check("midrst_pulse", 32'(edge_pulse), 32'h0);
        in = 4'h7;
        step(2);
        check("postrst_nopulse", 32'(edge_pulse), 32'h0);
        step(1);
        check("postrst_pulse", 32'(edge_pulse), 32'h8);
        check("postrst_level", 32'(level), 32'h7);

        // clear coincident with a qualifying edge: set wins
        in = 4'hF;
        step(2);
        clr = 4'h8;
        step(1);
        clr = '0;
        check("setwins_pending", 32'(pending), 32'h8);
        check("setwins_pulse", 32'(edge_pulse), 32'h8);
        clr = 4'h8;
        step(1);
        clr = '0;
        check("clr3_pending", 32'(pending), 32'h0);
        check("clr3_irq", 32'(irq), 32'h0);

        // clk_en low freezes the filter
        clk_en = 1'b0;
        in = 4'h0;
        step(10);
        check("freeze_level", 32'(level), 32'hF);
        check("freeze_pulse", 32'(edge_pulse), 32'h0);
        clk_en = 1'b1;
        in = 4'hF;
        step(1);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 3) == 0) in[i] = ~in[i];
            clk_en  = ($urandom_range(0, 3) != 0);
            clr     = NCH'($urandom_range(0, 15) & (($urandom_range(0, 7) == 0) ? 15 : 0));
            reset_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Multi-channel successor to the single-bit edge detector.
- Each of NUM_CH synchronous inputs passes through a per-channel glitch filter, gated by clk_en.
- Qualifying edges are selected per channel at run time: off, rising, falling or both.
- Outputs per channel: a registered one-clock pulse and a sticky pending flag with clear. A global irq is the OR of the pending flags.
- Sits between the register/timer logic and the OPL3 status/IRQ path; replaces ad-hoc instances of the single detector.

Parameters:
- NUM_CH, 8, number of independent channels (1..32).
- FILTER_CYCLES, 1, consecutive clk_en samples of a new level required before it is accepted (1..255). A value of 1 means no filtering.
- INITIAL_INPUT_LEVEL, 0, reset value of every channel's filtered level.
- CNT_W, 8, width of each optional per-channel edge counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous reset, active-low.
- clk_en  input  1  sample qualifier; filters advance only when high.
- in  input  NUM_CH  raw channel inputs, synchronous to clk.
- mode  input  2*NUM_CH  per channel {mode[2i+1],mode[2i]}: 00 off, 01 rising, 10 falling, 11 both.
- clr  input  NUM_CH  per-channel clear of pending (and of count when enabled).
- level  output  NUM_CH  filtered, registered level per channel.
- edge_pulse  output  NUM_CH  one-clk pulse per qualifying edge.
- pending  output  NUM_CH  sticky qualifying-edge flags.
- irq  output  1  |pending, registered.
- edge_count  output  NUM_CH*CNT_W  per-channel edge counters; all zero without the optional feature.

Behaviour:
- Reset: reset_n low at a clk posedge sets:
  - level to {NUM_CH{INITIAL_INPUT_LEVEL}};
  - filter counters, edge_pulse, pending, irq and edge_count to 0.
  - Reset overrides clk_en and clr. Reset mid-filter discards partial counts, and no pulse is generated for the reset-induced level change.
- Filter, per channel, on each posedge with clk_en=1:
  - if in[i]==level[i]: cnt<=0;
  - else if cnt==FILTER_CYCLES-1: level[i]<=in[i], cnt<=0, raw edge event;
  - else cnt<=cnt+1.
  - Counter width is clog2(FILTER_CYCLES+1).
  - A glitch shorter than FILTER_CYCLES samples resets cnt and produces no event.
- clk_en=0: filter state and level hold; edge_pulse is 0 that cycle.
- Qualification: event is rising if the new level is 1, falling if 0. A rising event qualifies for mode 01 or 11; a falling event for mode 10 or 11. Mode 00 produces no outputs, but level still tracks. mode is sampled at the same edge as the event.
- Latency: edge_pulse[i] and level[i] update on the same posedge, at the FILTER_CYCLES-th consecutive differing clk_en sample. The pulse is high exactly one clk cycle, even if clk_en stays high.
- pending[i]: set on a qualifying edge and held until clr[i]. clr acts on any cycle regardless of clk_en. Simultaneous set and clr leaves pending=1 (set wins).
- irq: registered OR of next-state pending, so it rises in the same cycle as pending.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

Optional Feature:
- Macro: EDGE_DETECTOR_MULTI_COUNT_EN.
- Defined: each channel has a CNT_W-bit counter that increments on every qualifying edge and saturates at all-ones (no wrap). clr[i] zeroes it; clr with a simultaneous qualifying edge gives count=1. Counter i occupies edge_count[i*CNT_W +: CNT_W].
- Undefined: no counter logic is built and edge_count is tied to 0.

Test Plan:
- NUM_CH=4, FILTER_CYCLES=1, mode=all 01, clk_en=1, in[0] 0->1 -> edge_pulse=0001 for 1 clk on the next posedge; level[0]=1, pending=0001, irq=1; in[0] 1->0 gives no pulse.
- FILTER_CYCLES=3, 2-sample high glitch on in[1] -> no pulse and level unchanged; then a 3-sample high -> pulse on the 3rd sample edge.
- mode ch2=11, clk_en high every 4th clk, in[2] toggles -> a pulse on each accepted change, aligned to clk_en cycles; clk_en=0 for 10 clks -> level frozen.
- pending[3] set, then clr[3] on the same cycle as a new qualifying edge -> pending[3] stays 1; clr[3] alone -> pending=0, irq=0 next cycle.
- Assert reset_n=0 while filter cnt=2 of 3 with INITIAL_INPUT_LEVEL=1 -> level=all 1s; all outputs 0; no pulse after release until a full 3 differing samples.
- With EDGE_DETECTOR_MULTI_COUNT_EN and CNT_W=2: 5 rising edges on ch0 -> count=3 (saturated); clr[0] -> 0; clr plus edge -> 1.
